// File: rtl/pe_bram_host.sv
`default_nettype none
// pe_bram_host: host-side word memory and sequencer for the PE array controller's BRAM port.
// Fills memory from a host stream, kicks the controller, then drains the result vector. Rev 1.0
module pe_bram_host #(
    parameter int VECTOR_SIZE = 64,
    parameter int L_RAM_SIZE  = 6,
    parameter int DEPTH       = VECTOR_SIZE * (VECTOR_SIZE + 1),
    parameter int TIMEOUT     = 2 ** 20
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] BRAM_ADDR,
    input  logic [31:0] BRAM_WRDATA,
    input  logic [3:0]  BRAM_WE,
    output logic [31:0] BRAM_RDDATA,
    output logic        pe_start,
    input  logic        pe_done,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        err
);
    localparam int AW = 2 * L_RAM_SIZE + 1;
    localparam int VW = L_RAM_SIZE + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_KICK  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t        state_q;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] fill_cnt_q;
    logic [TW-1:0] wait_cnt_q;
    logic [VW-1:0] rd_cnt_q;
    logic [31:0]   rd_data_q;
    logic          rd_vld_q;
    logic          rd_last_q;
    logic [31:0]   rddata_q;
    logic [31:0]   m_data_q;
    logic          pe_start_q;
    logic          s_ready_q;
    logic          m_valid_q;
    logic          m_last_q;
    logic          busy_q;
    logic          err_q;

    logic [AW-1:0] idx;
    logic          idx_ok;
    logic          fill_fire;
    logic          ctl_we;
    logic          drain_load;
    logic          drain_issue;
    logic [AW-1:0] drain_addr;
    logic          unused_addr;

    assign idx         = BRAM_ADDR[AW+1:2];
    assign idx_ok      = 32'(idx) < 32'(DEPTH);
    assign unused_addr = ^{BRAM_ADDR[31:AW+2], BRAM_ADDR[1:0]};
    assign fill_fire   = (state_q == ST_FILL) && s_valid && s_ready_q;
    assign ctl_we      = (state_q == ST_WAIT) && idx_ok;

    // One-word prefetch stage (rd_*) feeding the output register: a new read is
    // issued whenever the prefetch slot is empty or is being moved to the output.
    assign drain_load  = rd_vld_q && (!m_valid_q || m_ready);
    assign drain_issue = (state_q == ST_DRAIN) && (rd_cnt_q < VW'(VECTOR_SIZE))
                         && (!rd_vld_q || drain_load);
    assign drain_addr  = AW'(rd_cnt_q);

    // Memory has no reset; FILL and WAIT never overlap so one write port suffices.
    always_ff @(posedge aclk) begin
        if (ctl_we) begin
            for (int b = 0; b < 4; b++) begin
                if (BRAM_WE[b]) mem_q[idx][8*b +: 8] <= BRAM_WRDATA[8*b +: 8];
            end
        end else if (fill_fire) begin
            mem_q[fill_cnt_q] <= s_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            wait_cnt_q <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            rddata_q   <= '0;
            m_data_q   <= '0;
            pe_start_q <= 1'b0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rddata_q   <= idx_ok ? mem_q[idx] : 32'h0;
            pe_start_q <= 1'b0;

            if (drain_issue) begin
                rd_data_q <= mem_q[drain_addr];
                rd_last_q <= (rd_cnt_q == VW'(VECTOR_SIZE - 1));
                rd_cnt_q  <= rd_cnt_q + 1'b1;
                rd_vld_q  <= 1'b1;
            end else if (drain_load) begin
                rd_vld_q  <= 1'b0;
            end

            if (drain_load) begin
                m_data_q  <= rd_data_q;
                m_last_q  <= rd_last_q;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        state_q    <= ST_FILL;
                        s_ready_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        fill_cnt_q <= '0;
                    end
                end
                ST_FILL: begin
                    if (fill_fire) begin
                        if (fill_cnt_q == AW'(DEPTH - 1)) begin
                            state_q    <= ST_KICK;
                            s_ready_q  <= 1'b0;
                            pe_start_q <= 1'b1;
                            fill_cnt_q <= '0;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + 1'b1;
                        end
                    end
                end
                ST_KICK: begin
                    state_q    <= ST_WAIT;
                    wait_cnt_q <= '0;
                end
                ST_WAIT: begin
                    if (pe_done) begin
                        state_q    <= ST_DRAIN;
                        wait_cnt_q <= '0;
                        rd_cnt_q   <= '0;
                    end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_q    <= ST_IDLE;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (m_valid_q && m_ready && m_last_q) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        rd_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BRAM_RDDATA = rddata_q;
    assign pe_start    = pe_start_q;
    assign s_ready     = s_ready_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_bram_host.sv
`default_nettype none
// tb_pe_bram_host: drives pe_bram_host with directed and random traffic and
// compares every observed word against an array model of the memory.
module tb_pe_bram_host;
    localparam int VS    = 64;
    localparam int DEPTH = VS * (VS + 1);
    localparam int T_DEPTH = 20;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] BRAM_ADDR, BRAM_WRDATA, BRAM_RDDATA;
    logic [3:0]  BRAM_WE;
    logic        pe_start, pe_done;
    logic [31:0] s_data, m_data;
    logic        s_valid, s_ready, m_valid, m_ready, m_last, busy, err;

    logic [31:0] t_addr, t_wrdata, t_rddata, t_s_data, t_m_data;
    logic [3:0]  t_we;
    logic        t_pe_start, t_pe_done, t_s_valid, t_s_ready, t_m_valid, t_m_ready;
    logic        t_m_last, t_busy, t_err;

    pe_bram_host u_dut (
        .aclk(aclk), .aresetn(aresetn), .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA),
        .BRAM_WE(BRAM_WE), .BRAM_RDDATA(BRAM_RDDATA), .pe_start(pe_start), .pe_done(pe_done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy), .err(err)
    );

    pe_bram_host #(.VECTOR_SIZE(4), .L_RAM_SIZE(2), .TIMEOUT(16)) u_dut_to (
        .aclk(aclk), .aresetn(aresetn), .BRAM_ADDR(t_addr), .BRAM_WRDATA(t_wrdata),
        .BRAM_WE(t_we), .BRAM_RDDATA(t_rddata), .pe_start(t_pe_start), .pe_done(t_pe_done),
        .s_data(t_s_data), .s_valid(t_s_valid), .s_ready(t_s_ready), .m_data(t_m_data),
        .m_valid(t_m_valid), .m_ready(t_m_ready), .m_last(t_m_last), .busy(t_busy), .err(t_err)
    );

    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] model_mem [DEPTH];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (we[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        return (idx < DEPTH) ? model_mem[idx] : 32'h0;
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] we);
        if (idx < DEPTH) model_mem[idx] = (model_mem[idx] & ~lane_mask(we)) | (d & lane_mask(we));
    endtask

    task automatic ctl_access(input int idx, input logic [31:0] d, input logic [3:0] we,
                              output logic [31:0] rd);
        BRAM_ADDR = 32'(idx) << 2;
        BRAM_WRDATA = d;
        BRAM_WE = we;
        tick();
        rd = BRAM_RDDATA;
        BRAM_WE = 4'h0;
    endtask

    // Streams DEPTH words; optionally holds a controller write to word 2 during FILL.
    task automatic fill_main(input bit rand_mode, input bit hold_ctl);
        int k = 0, guard = 0, starts = 0;
        logic hs;
        s_data = rand_mode ? $urandom : 32'h0;
        if (hold_ctl) begin
            BRAM_ADDR = 32'h8; BRAM_WRDATA = 32'hAABBCCDD; BRAM_WE = 4'b0011;
        end
        while (k < DEPTH && guard < 4 * DEPTH + 100) begin
            s_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            hs = s_valid && s_ready;
            tick();
            guard++;
            starts += int'(pe_start);
            if (hs) begin
                model_mem[k] = s_data;
                k++;
                s_data = rand_mode ? $urandom : 32'(k);
            end
        end
        s_valid = 1'b0;
        BRAM_WE = 4'h0;
        n_total++;
        if (k != DEPTH) $display("FAIL fill_handshakes: got %0d required %0d", k, DEPTH);
        else n_pass++;
        n_total++;
        if (pe_start !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL kick_after_last: pe_start=%b s_ready=%b required 1/0", pe_start, s_ready);
        else n_pass++;
        tick();
        starts += int'(pe_start);
        n_total++;
        if (starts != 1 || pe_start !== 1'b0)
            $display("FAIL start_pulse_count: got %0d pulses (now %b) required 1 (now 0)", starts, pe_start);
        else n_pass++;
    endtask

    task automatic run_drain(input bit rand_ready);
        int n = 0, cyc = 0, extra = 0;
        bit seen = 0, stalled = 0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        cyc = 1;
        while (n < VS && cyc < 2000) begin
            m_ready = rand_ready ? 1'($urandom_range(0, 1))
                                 : (((cyc - 3) % 4 == 0) || ((cyc - 3) % 4 == 3));
            if (m_valid && !seen) begin
                seen = 1;
                n_total++;
                if (cyc != 3) $display("FAIL first_valid_latency: got %0d required 3", cyc);
                else n_pass++;
            end
            if (stalled) begin
                n_total++;
                if (m_valid !== 1'b1 || m_data !== hd || m_last !== hl)
                    $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             m_valid, m_data, m_last, hd, hl);
                else n_pass++;
            end
            stalled = 0;
            if (m_valid) begin
                if (m_ready) begin
                    n_total++;
                    if (m_data !== model_mem[n] || m_last !== (n == VS - 1))
                        $display("FAIL drain_word[%0d]: got %h last=%b required %h last=%b",
                                 n, m_data, m_last, model_mem[n], (n == VS - 1));
                    else n_pass++;
                    n++;
                end else begin
                    stalled = 1; hd = m_data; hl = m_last;
                end
            end
            tick();
            cyc++;
        end
        n_total++;
        if (n != VS || m_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL drain_end: words=%0d m_valid=%b busy=%b required %0d/0/0", n, m_valid, busy, VS);
        else n_pass++;
        m_ready = 1'b1;
        repeat (4) begin
            tick();
            extra += int'(m_valid);
        end
        m_ready = 1'b0;
        n_total++;
        if (extra != 0) $display("FAIL drain_extra_words: got %0d required 0", extra);
        else n_pass++;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) tick();
        n_total++;
        if ({BRAM_RDDATA, pe_start, s_ready, m_data, m_valid, m_last, busy, err} !== '0)
            $display("FAIL reset_values: got %h required 0",
                     {BRAM_RDDATA, pe_start, s_ready, m_data, m_valid, m_last, busy, err});
        else n_pass++;
        aresetn = 1'b1;
        tick();
        s_valid = 1'b1; s_data = 32'h55;
        repeat (3) tick();
        n_total++;
        if (s_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL fill_entry: s_ready=%b busy=%b required 1/1", s_ready, busy);
        else n_pass++;
        #2 aresetn = 1'b0;
        #1;
        n_total++;
        if ({BRAM_RDDATA, pe_start, s_ready, m_data, m_valid, m_last, busy, err} !== '0)
            $display("FAIL async_reset: got %h required 0",
                     {BRAM_RDDATA, pe_start, s_ready, m_data, m_valid, m_last, busy, err});
        else n_pass++;
        s_valid = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) tick();
        n_total++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || t_busy !== 1'b0)
            $display("FAIL idle_after_reset: s_ready=%b busy=%b t_busy=%b required 0/0/0",
                     s_ready, busy, t_busy);
        else n_pass++;
    endtask

    task automatic test_fill_start();
        logic [31:0] rd;
        int ks[3] = '{0, 64, 4159};
        fill_main(1'b0, 1'b0);
        foreach (ks[i]) begin
            ctl_access(ks[i], 32'h0, 4'h0, rd);
            n_total++;
            if (rd !== model_read(ks[i])) $display("FAIL wait_read[%0d]: got %h required %h", ks[i], rd, model_read(ks[i]));
            else n_pass++;
        end
    endtask

    task automatic test_read_first_and_lanes();
        logic [31:0] rd;
        logic [31:0] d = $urandom;
        ctl_access(10, d, 4'hF, rd);
        n_total++;
        if (rd !== model_read(10)) $display("FAIL read_first: got %h required %h", rd, model_read(10));
        else n_pass++;
        model_write(10, d, 4'hF);
        ctl_access(10, 32'h0, 4'h0, rd);
        n_total++;
        if (rd !== model_read(10)) $display("FAIL write_then_read: got %h required %h", rd, model_read(10));
        else n_pass++;
        ctl_access(2, 32'hAABBCCDD, 4'b0011, rd);
        model_write(2, 32'hAABBCCDD, 4'b0011);
        ctl_access(2, 32'h0, 4'h0, rd);
        n_total++;
        if (rd !== model_read(2) || rd !== 32'h0000CCDD)
            $display("FAIL byte_lane: got %h required %h", rd, model_read(2));
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        ctl_access(DEPTH, 32'h0, 4'h0, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL oor_read: got %h required 0", rd);
        else n_pass++;
        ctl_access(DEPTH, 32'hDEADBEEF, 4'hF, rd);
        ctl_access(DEPTH, 32'h0, 4'h0, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL oor_read_after_write: got %h required 0", rd);
        else n_pass++;
        foreach (model_mem[i]) begin
            if (i == 0 || i == 64 || i == DEPTH - 1) begin
                ctl_access(i, 32'h0, 4'h0, rd);
                n_total++;
                if (rd !== model_read(i)) $display("FAIL oor_no_alias[%0d]: got %h required %h", i, rd, model_read(i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_drain_backpressure();
        logic [31:0] rd;
        for (int i = 0; i < VS; i++) begin
            ctl_access(i, 32'(100 + i), 4'hF, rd);
            model_write(i, 32'(100 + i), 4'hF);
        end
        run_drain(1'b0);
    endtask

    task automatic test_random_run();
        logic [31:0] rd, d;
        logic [3:0] we;
        int idx;
        fill_main(1'b1, 1'b1);
        ctl_access(2, 32'h0, 4'h0, rd);
        n_total++;
        if (rd !== model_read(2)) $display("FAIL fill_ignores_ctl_write: got %h required %h", rd, model_read(2));
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            idx = (i % 5 == 0) ? int'($urandom_range(DEPTH - 2, DEPTH + 3)) : int'($urandom_range(0, 127));
            d = $urandom;
            we = 4'($urandom);
            ctl_access(idx, d, we, rd);
            n_total++;
            if (rd !== model_read(idx)) $display("FAIL rand_access[%0d]: got %h required %h", idx, rd, model_read(idx));
            else n_pass++;
            model_write(idx, d, we);
        end
        run_drain(1'b1);
    endtask

    task automatic test_timeout();
        int k = 0, guard = 0;
        logic hs;
        t_s_valid = 1'b1;
        while (k < T_DEPTH && guard < 200) begin
            t_s_data = $urandom;
            hs = t_s_ready;
            tick();
            guard++;
            if (hs) k++;
        end
        t_s_valid = 1'b0;
        n_total++;
        if (t_pe_start !== 1'b1) $display("FAIL to_kick: pe_start=%b required 1", t_pe_start);
        else n_pass++;
        repeat (16) tick();
        n_total++;
        if (t_err !== 1'b0 || t_busy !== 1'b1)
            $display("FAIL to_before_limit: err=%b busy=%b required 0/1", t_err, t_busy);
        else n_pass++;
        tick();
        n_total++;
        if (t_err !== 1'b1 || t_busy !== 1'b0)
            $display("FAIL to_expired: err=%b busy=%b required 1/0", t_err, t_busy);
        else n_pass++;
        tick();
        n_total++;
        if (t_err !== 1'b1) $display("FAIL to_sticky: err=%b required 1", t_err);
        else n_pass++;
        t_s_valid = 1'b1;
        tick();
        t_s_valid = 1'b0;
        n_total++;
        if (t_err !== 1'b0 || t_s_ready !== 1'b1 || t_busy !== 1'b1)
            $display("FAIL to_err_clear: err=%b s_ready=%b busy=%b required 0/1/1", t_err, t_s_ready, t_busy);
        else n_pass++;
    endtask

    initial begin
        aresetn = 1'b0;
        BRAM_ADDR = '0; BRAM_WRDATA = '0; BRAM_WE = '0; pe_done = 1'b0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
        t_addr = '0; t_wrdata = '0; t_we = '0; t_pe_done = 1'b0;
        t_s_data = '0; t_s_valid = 1'b0; t_m_ready = 1'b0;
        test_reset();
        test_fill_start();
        test_read_first_and_lanes();
        test_out_of_range();
        test_drain_backpressure();
        test_random_run();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
